// File: rtl/seven_seg_pkg.sv
// Segment code constants and BCD-to-segment decode for the 7-segment scanner.
// Codes are active-high {a,b,c,d,e,f,g}; polarity is applied at the output register.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1110011;
  localparam logic [6:0] SEG_ERR = 7'b0000001;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Non-decimal nibbles show the error glyph (segment g only).
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_ERR;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// BCD word handshake between the BCD producer (master) and the scanner (slave).
interface seven_seg_scanner_if #(
  parameter int unsigned N_DIGITS = 4
) ();

  logic                    bcd_valid;
  logic [4*N_DIGITS-1:0]   bcd_in;
  logic                    bcd_ready;

  modport master (output bcd_valid, output bcd_in, input bcd_ready);
  modport slave  (input bcd_valid, input bcd_in, output bcd_ready);

endinterface

// File: rtl/seg_scan_timer.sv
// Free-running dwell/digit counters for the scan, plus frame-end flag and PWM gate.
// frame_end_o is registered and aligned with the last cycle of each frame.
module seg_scan_timer #(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned REFRESH_CYCLES = 168,
  parameter int unsigned DIM_BITS       = 3,
  localparam int unsigned IDX_W         = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIM_BITS-1:0] brightness_i,
  output logic [IDX_W-1:0]    digit_idx_o,
  output logic                frame_end_o,
  output logic                pwm_on_c
);

  localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);
  localparam int unsigned PWM_W = CNT_W + DIM_BITS + 1;

  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_end_q, frame_end_d;
  logic [PWM_W-1:0] pwm_lhs, pwm_rhs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q     <= '0;
      idx_q       <= '0;
      frame_end_q <= 1'b0;
    end else begin
      dwell_q     <= dwell_d;
      idx_q       <= idx_d;
      frame_end_q <= frame_end_d;
    end
  end

  // Advance dwell; step digit on dwell wrap; predict frame end one cycle ahead.
  always_comb begin
    dwell_d = dwell_q + CNT_W'(1);
    idx_d   = idx_q;
    if (dwell_q == CNT_W'(REFRESH_CYCLES - 1)) begin
      dwell_d = '0;
      idx_d   = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    frame_end_d = (dwell_d == CNT_W'(REFRESH_CYCLES - 1)) &&
                  (idx_d == IDX_W'(N_DIGITS - 1));
  end

  // Duty gate; width is sized so the products never overflow.
  always_comb begin
    pwm_lhs  = PWM_W'(dwell_q) << DIM_BITS;
    pwm_rhs  = (PWM_W'(brightness_i) + PWM_W'(1)) * PWM_W'(REFRESH_CYCLES);
    pwm_on_c = (pwm_lhs < pwm_rhs);
  end

  assign digit_idx_o = idx_q;
  assign frame_end_o = frame_end_q;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit 7-segment driver with a tear-free shadow buffer,
// leading-zero blanking, error glyph, PWM dimming and configurable polarity.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS            = 4,
  parameter int unsigned REFRESH_CYCLES      = 168,
  parameter int unsigned DIM_BITS            = 3,
  parameter int unsigned SEG_ACTIVE_HIGH     = 1,
  parameter int unsigned SEL_ACTIVE_HIGH     = 1,
  parameter int unsigned BLANK_LEADING_ZEROS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  seven_seg_scanner_if.slave   bcd_bus,
  input  logic [DIM_BITS-1:0]  brightness,
  output logic [6:0]           segments,
  output logic [N_DIGITS-1:0]  display_select,
  output logic                 frame_tick
);

  localparam int unsigned DATA_W = 4 * N_DIGITS;
  localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [6:0]          SEG_IDLE = (SEG_ACTIVE_HIGH != 0) ? SEG_OFF : ~SEG_OFF;
  localparam logic [N_DIGITS-1:0] SEL_IDLE = (SEL_ACTIVE_HIGH != 0) ? '0 : '1;

  logic [IDX_W-1:0]    digit_idx;
  logic                frame_end;
  logic                pwm_on;

  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   disp_q, disp_d;
  logic                has_data_q, has_data_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] sel_q, sel_d;

  logic [DATA_W-1:0]   upper;
  logic                blank;
  logic [6:0]          seg_raw;
  logic [N_DIGITS-1:0] sel_raw;

  seg_scan_timer #(
    .N_DIGITS       (N_DIGITS),
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .DIM_BITS       (DIM_BITS)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .brightness_i (brightness),
    .digit_idx_o  (digit_idx),
    .frame_end_o  (frame_end),
    .pwm_on_c     (pwm_on)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q    <= 1'b1;
      shadow_q   <= '0;
      disp_q     <= '0;
      has_data_q <= 1'b0;
      seg_q      <= SEG_IDLE;
      sel_q      <= SEL_IDLE;
    end else begin
      ready_q    <= ready_d;
      shadow_q   <= shadow_d;
      disp_q     <= disp_d;
      has_data_q <= has_data_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end

  // Commit a full shadow at frame end; otherwise accept into an empty shadow.
  always_comb begin
    ready_d    = ready_q;
    shadow_d   = shadow_q;
    disp_d     = disp_q;
    has_data_d = has_data_q;
    if (frame_end && !ready_q) begin
      disp_d     = shadow_q;
      has_data_d = 1'b1;
      ready_d    = 1'b1;
    end else if (bcd_bus.bcd_valid && ready_q) begin
      shadow_d = bcd_bus.bcd_in;
      ready_d  = 1'b0;
    end
  end

  // upper holds nibbles digit_idx..N-1, so zero means this digit is a leading zero.
  always_comb begin
    upper   = disp_q >> {digit_idx, 2'b00};
    blank   = !has_data_q || !pwm_on ||
              ((BLANK_LEADING_ZEROS != 0) && (digit_idx != '0) && (upper == '0));
    seg_raw = blank ? SEG_OFF : bcd_to_seg(upper[3:0]);
    sel_raw = blank ? '0 : (N_DIGITS'(1) << digit_idx);
    seg_d   = (SEG_ACTIVE_HIGH != 0) ? seg_raw : ~seg_raw;
    sel_d   = (SEL_ACTIVE_HIGH != 0) ? sel_raw : ~sel_raw;
  end

  assign bcd_bus.bcd_ready = ready_q;
  assign segments          = seg_q;
  assign display_select    = sel_q;
  assign frame_tick        = frame_end;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: a frame-level reference model queues expected outputs each
// cycle; a monitor on the falling edge pops and compares both polarity variants.
module tb_seven_seg_scanner;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int D     = 2;
  localparam int FRAME = N * R;

  logic         clk = 1'b0;
  logic         reset;
  logic [D-1:0] brightness;
  logic [6:0]   seg, seg_inv;
  logic [N-1:0] sel, sel_inv;
  logic         tick, tick_inv;

  seven_seg_scanner_if #(.N_DIGITS(N)) bus ();
  seven_seg_scanner_if #(.N_DIGITS(N)) bus_inv ();

  seven_seg_scanner #(
    .N_DIGITS(N), .REFRESH_CYCLES(R), .DIM_BITS(D),
    .SEG_ACTIVE_HIGH(1), .SEL_ACTIVE_HIGH(1), .BLANK_LEADING_ZEROS(1)
  ) u_dut (
    .clk(clk), .reset(reset), .bcd_bus(bus.slave), .brightness(brightness),
    .segments(seg), .display_select(sel), .frame_tick(tick)
  );

  seven_seg_scanner #(
    .N_DIGITS(N), .REFRESH_CYCLES(R), .DIM_BITS(D),
    .SEG_ACTIVE_HIGH(0), .SEL_ACTIVE_HIGH(0), .BLANK_LEADING_ZEROS(1)
  ) u_dut_inv (
    .clk(clk), .reset(reset), .bcd_bus(bus_inv.slave), .brightness(brightness),
    .segments(seg_inv), .display_select(sel_inv), .frame_tick(tick_inv)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]   seg;
    logic [N-1:0] sel;
    logic         tick;
    logic         ready;
  } exp_t;

  localparam exp_t IDLE = '{seg: 7'b0, sel: '0, tick: 1'b0, ready: 1'b1};

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: cycles since reset, buffered and displayed words.
  int          cyc;
  logic        m_ready, m_has;
  logic [15:0] m_shadow, m_disp;

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1110011;
      default: return 7'b0000001;
    endcase
  endfunction

  // Number of digits that are shown once leading zeros are suppressed (at least 1).
  function automatic int sig_digits(input logic [15:0] w);
    int s = 1;
    for (int k = 0; k < N; k++)
      if (((w >> (4 * k)) & 16'hF) != 16'h0) s = k + 1;
    return s;
  endfunction

  always @(posedge clk) begin : model
    exp_t e;
    int   dwell, digit, nib;
    bit   lit;
    if (reset) begin
      cyc      = 0;
      m_ready  = 1'b1;
      m_has    = 1'b0;
      m_shadow = '0;
      m_disp   = '0;
      e        = IDLE;
    end else begin
      dwell = cyc % R;
      digit = (cyc / R) % N;
      nib   = int'((m_disp >> (4 * digit)) & 16'hF);
      lit   = m_has && (dwell * (1 << D) < (int'(brightness) + 1) * R) &&
              (digit < sig_digits(m_disp));
      e.seg = lit ? glyph(nib) : 7'b0;
      e.sel = lit ? N'(1 << digit) : '0;
      if ((cyc % FRAME) == FRAME - 1 && !m_ready) begin
        m_disp  = m_shadow;
        m_has   = 1'b1;
        m_ready = 1'b1;
      end else if (bus.bcd_valid && m_ready) begin
        m_shadow = bus.bcd_in;
        m_ready  = 1'b0;
      end
      cyc     = cyc + 1;
      e.tick  = ((cyc % FRAME) == FRAME - 1);
      e.ready = m_ready;
    end
    q.push_back(e);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t         e;
    logic [6:0]   iseg;
    logic [N-1:0] isel;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (reset) e = IDLE;
      iseg = ~e.seg;
      isel = ~e.sel;
      check("segments",       32'(seg),             32'(e.seg));
      check("select",         32'(sel),             32'(e.sel));
      check("frame_tick",     32'(tick),            32'(e.tick));
      check("bcd_ready",      32'(bus.bcd_ready),   32'(e.ready));
      check("segments_inv",   32'(seg_inv),         32'(iseg));
      check("select_inv",     32'(sel_inv),         32'(isel));
      check("frame_tick_inv", 32'(tick_inv),        32'(e.tick));
      check("bcd_ready_inv",  32'(bus_inv.bcd_ready), 32'(e.ready));
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] w);
    bus.bcd_valid     = v;
    bus.bcd_in        = w;
    bus_inv.bcd_valid = v;
    bus_inv.bcd_in    = w;
  endtask

  task automatic send(input logic [15:0] w, input int hold);
    drive(1'b1, w);
    cycles(hold);
    drive(1'b0, w);
  endtask

  initial begin
    logic [15:0] w;
    reset      = 1'b1;
    brightness = 2'd3;
    drive(1'b0, 16'h0);
    cycles(3);
    reset = 1'b0;

    // Idle frames, then a single-cycle word and full-brightness scan.
    cycles(32);
    send(16'h1234, 1);
    cycles(40);

    // Dimming levels.
    brightness = 2'd0;
    cycles(20);
    brightness = 2'd1;
    cycles(20);
    brightness = 2'd3;

    // Leading-zero blanking, all-zero word, error glyph.
    send(16'h0007, 20);
    cycles(40);
    send(16'h0000, 20);
    cycles(40);
    send(16'h00A5, 20);
    cycles(40);

    // Back-to-back words while the shadow is full, then reset mid-frame.
    send(16'h1111, 5);
    drive(1'b1, 16'h2222);
    cycles(6);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    drive(1'b0, 16'h0);
    cycles(40);

    // Randomised words, holds, gaps and brightness changes.
    repeat (25) begin
      w = 16'($urandom());
      if ($urandom_range(0, 1) == 1) w = w >> (4 * $urandom_range(1, 3));
      brightness = D'($urandom_range(0, 3));
      send(w, $urandom_range(1, 20));
      cycles($urandom_range(0, 12));
      brightness = D'($urandom_range(0, 3));
      cycles($urandom_range(0, 20));
    end

    // Reset at an arbitrary phase and confirm the display stays dark afterwards.
    cycles($urandom_range(0, 15));
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
